// File: rtl/mem_io_bridge_pkg.sv
// Shared definitions for the CPU memory/IO bridge.
// Covers the IO address map, read-return source tags and stop-sequence states.
package mem_io_bridge_pkg;

  localparam logic [31:0] IO_BASE = 32'h0003_0000;
  localparam logic [1:0]  IO_UART = 2'b00;  // word offset of 0x30000
  localparam logic [1:0]  IO_CLK  = 2'b01;  // word offset of 0x30004

  typedef enum logic [1:0] {
    RD_RAM = 2'd0,
    RD_RX  = 2'd1,
    RD_CLK = 2'd2
  } rd_src_e;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } stop_state_e;

  function automatic logic [7:0] word_byte(input logic [31:0] w, input logic [1:0] idx);
    logic [7:0] b;
    case (idx)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    return b;
  endfunction

endpackage

// File: rtl/mem_io_bridge_if.sv
// Byte-wide CPU memory bus between the cpu top (master) and the bridge (slave).
interface mem_io_bridge_if;
  logic [31:0] mem_a;
  logic [7:0]  mem_dout;
  logic        mem_wr;
  logic [7:0]  mem_din;
  logic        io_buffer_full;

  modport master (output mem_a, mem_dout, mem_wr, input mem_din, io_buffer_full);
  modport slave  (input mem_a, mem_dout, mem_wr, output mem_din, io_buffer_full);
endinterface

// File: rtl/mem_io_bridge_sync_fifo.sv
// First-word-fall-through synchronous FIFO with occupancy outputs.
// A pop frees a slot for a push in the same cycle; a push into an empty FIFO is visible next cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   count,
  output logic [$clog2(DEPTH):0]   count_next
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count_reg == '0);
  assign full    = (count_reg == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  always_comb begin
    count_next = count_reg;
    if (do_push && !do_pop) begin
      count_next = count_reg + 1'b1;
    end else if (do_pop && !do_push) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      count_reg <= count_next;
    end
  end

  // Storage carries no reset so it can map onto distributed RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= wdata;
  end

  assign rdata = mem[rd_ptr_reg];
  assign count = count_reg;

endmodule

// File: rtl/mem_io_bridge.sv
// Routes CPU byte accesses to RAM or the UART/cycle-counter IO page, buffers TX bytes,
// returns read data one cycle after the request and runs the program-stop sequence.
module mem_io_bridge
  import mem_io_bridge_pkg::*;
#(
  parameter int TX_DEPTH    = 16,
  parameter int FULL_MARGIN = 2,
  parameter int RAM_AW      = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              rdy_in,
  mem_io_bridge_if.slave    bus,
  output logic              ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  input  logic [7:0]        ram_rdata,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_pop,
  output logic              program_finish,
  output logic              tx_overflow
);
  localparam int CW = $clog2(TX_DEPTH) + 1;

  logic io_sel, is_uart, is_clk, is_clk0;
  logic rd_access, wr_access, uart_wr, stop_wr;
  logic unused_hi;

  assign io_sel    = (bus.mem_a[17:16] == IO_BASE[17:16]);
  assign is_uart   = io_sel & (bus.mem_a[3:2] == IO_UART) & (bus.mem_a[1:0] == 2'b00);
  assign is_clk    = io_sel & (bus.mem_a[3:2] == IO_CLK);
  assign is_clk0   = is_clk & (bus.mem_a[1:0] == 2'b00);
  assign rd_access = rdy_in & ~bus.mem_wr;
  assign wr_access = rdy_in & bus.mem_wr;
  assign unused_hi = ^bus.mem_a[31:18];

  assign ram_addr  = bus.mem_a[RAM_AW-1:0];
  assign ram_wdata = bus.mem_dout;
  assign ram_we    = wr_access & ~io_sel;
  assign rx_pop    = rd_access & is_uart & rx_valid;

  // ---------------- TX FIFO ----------------
  logic          fifo_push, fifo_pop, fifo_empty, fifo_full, fifo_has_slot;
  logic [7:0]    fifo_wdata;
  logic [CW-1:0] fifo_count, fifo_count_next;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_tx_fifo (
    .clk        (clk_in),
    .rst_n      (rst_in),
    .push       (fifo_push),
    .wdata      (fifo_wdata),
    .pop        (fifo_pop),
    .rdata      (tx_data),
    .empty      (fifo_empty),
    .full       (fifo_full),
    .count      (fifo_count),
    .count_next (fifo_count_next)
  );

  assign tx_valid      = ~fifo_empty;
  assign fifo_pop      = tx_valid & tx_ready;
  assign fifo_has_slot = ~fifo_full | fifo_pop;

  // ---------------- stop FSM + push arbitration ----------------
  stop_state_e state_reg, state_next;
  logic        stop_pend_reg, stop_pend_next;
  logic        overflow_set;
  logic        tx_overflow_reg;

  assign uart_wr = wr_access & is_uart & (bus.mem_dout != 8'h00) & (state_reg != ST_DONE);
  assign stop_wr = wr_access & is_clk0;

  always_comb begin
    state_next     = state_reg;
    stop_pend_next = stop_pend_reg;
    fifo_push      = 1'b0;
    fifo_wdata     = bus.mem_dout;
    overflow_set   = 1'b0;
    case (state_reg)
      ST_RUN: begin
        // The stop marker waits here for a free slot rather than being dropped.
        if (stop_pend_reg || stop_wr) begin
          if (fifo_has_slot) begin
            fifo_push      = 1'b1;
            fifo_wdata     = 8'h00;
            stop_pend_next = 1'b0;
            state_next     = ST_DRAIN;
          end else begin
            stop_pend_next = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (fifo_count == '0) state_next = ST_DONE;
      end
      default: ;
    endcase
    if (uart_wr) begin
      if (fifo_has_slot && !fifo_push) begin
        fifo_push  = 1'b1;
        fifo_wdata = bus.mem_dout;
      end else begin
        overflow_set = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg       <= ST_RUN;
      stop_pend_reg   <= 1'b0;
      tx_overflow_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      stop_pend_reg <= stop_pend_next;
      if (overflow_set) tx_overflow_reg <= 1'b1;
    end
  end

  assign program_finish = (state_reg == ST_DONE);
  assign tx_overflow    = tx_overflow_reg;

  // ---------------- read return, counter, full flag ----------------
  rd_src_e     rd_src_reg;
  logic        rd_valid_reg;
  logic [1:0]  rd_idx_reg;
  logic [7:0]  rx_byte_reg, din_hold_reg, din_mux;
  logic [31:0] cyc_cnt_reg, snap_reg;
  logic        io_full_reg, io_full_next;

  assign io_full_next = (TX_DEPTH - int'(fifo_count_next)) <= FULL_MARGIN;

  always_comb begin
    din_mux = ram_rdata;
    case (rd_src_reg)
      RD_RX:   din_mux = rx_byte_reg;
      RD_CLK:  din_mux = word_byte(snap_reg, rd_idx_reg);
      default: din_mux = ram_rdata;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      rd_valid_reg <= 1'b0;
      rd_src_reg   <= RD_RAM;
      rd_idx_reg   <= 2'd0;
      rx_byte_reg  <= 8'h00;
      din_hold_reg <= 8'h00;
      cyc_cnt_reg  <= 32'd0;
      snap_reg     <= 32'd0;
      io_full_reg  <= 1'b0;
    end else begin
      rd_valid_reg <= rd_access;
      if (rd_access) begin
        rd_idx_reg <= bus.mem_a[1:0];
        if (!io_sel) begin
          rd_src_reg <= RD_RAM;
        end else if (is_clk) begin
          rd_src_reg <= RD_CLK;
        end else begin
          // Unmapped IO offsets and an empty RX both read back as zero.
          rd_src_reg  <= RD_RX;
          rx_byte_reg <= (is_uart && rx_valid) ? rx_data : 8'h00;
        end
      end
      if (rd_access && is_clk0) snap_reg <= cyc_cnt_reg;
      if (rd_valid_reg) din_hold_reg <= din_mux;
      if (rdy_in) cyc_cnt_reg <= cyc_cnt_reg + 32'd1;
      io_full_reg <= io_full_next;
    end
  end

  assign bus.mem_din        = rd_valid_reg ? din_mux : din_hold_reg;
  assign bus.io_buffer_full = io_full_reg;

endmodule

// File: tb/tb_mem_io_bridge.sv
// Directed bench for mem_io_bridge: a vector table for single-cycle accesses plus
// hand-written sequences for the counter snapshot, TX FIFO limits and the stop sequence.
module tb_mem_io_bridge;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rdy = 1'b0;
  logic        ram_we;
  logic [16:0] ram_addr;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_pop;
  logic        program_finish;
  logic        tx_overflow;

  int checks = 0;
  int errors = 0;

  logic [7:0] ram [0:131071];
  logic [7:0] tx_q [$];

  always #5 clk = ~clk;

  mem_io_bridge_if bus ();

  mem_io_bridge dut (
    .clk_in         (clk),
    .rst_in         (rst_n),
    .rdy_in         (rdy),
    .bus            (bus),
    .ram_we         (ram_we),
    .ram_addr       (ram_addr),
    .ram_wdata      (ram_wdata),
    .ram_rdata      (ram_rdata),
    .tx_data        (tx_data),
    .tx_valid       (tx_valid),
    .tx_ready       (tx_ready),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_pop         (rx_pop),
    .program_finish (program_finish),
    .tx_overflow    (tx_overflow)
  );

  // Synchronous RAM with one-cycle read latency, and the UART sink.
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
    if (tx_valid && tx_ready) tx_q.push_back(tx_data);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, required to finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic r, input logic w, input logic [31:0] a, input logic [7:0] d);
    rdy          = r;
    bus.mem_wr   = w;
    bus.mem_a    = a;
    bus.mem_dout = d;
  endtask

  task automatic do_reset();
    rst_n    = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    #12;
    rst_n = 1'b1;
    step();
    tx_q.delete();
  endtask

  // One read access; the returned byte is checked one cycle later.
  task automatic rd(input logic [31:0] a, input logic [7:0] exp, input string name);
    drive(1'b1, 1'b0, a, 8'h00);
    step();
    check(name, bus.mem_din, exp);
    $display("read  0x%05h -> 0x%02h", a, bus.mem_din);
  endtask

  task automatic wr(input logic [31:0] a, input logic [7:0] d);
    drive(1'b1, 1'b1, a, d);
    step();
    $display("write 0x%05h <- 0x%02h", a, d);
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic        rxv;
    logic [7:0]  rxd;
    logic        exp_we;
    logic [16:0] exp_addr;
    logic        exp_pop;
    logic [7:0]  exp_din;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic got;
    logic prev_v, prev2_v, pf_prev;

    vecs[0]  = '{1'b1, 32'h0000_0100, 8'h41, 1'b0, 8'h00, 1'b1, 17'h00100, 1'b0, 8'h00};
    vecs[1]  = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b0, 17'h00100, 1'b0, 8'h41};
    vecs[2]  = '{1'b1, 32'hFFF1_FFFF, 8'h7E, 1'b0, 8'h00, 1'b1, 17'h1FFFF, 1'b0, 8'h41};
    vecs[3]  = '{1'b0, 32'h0001_FFFF, 8'h00, 1'b0, 8'h00, 1'b0, 17'h1FFFF, 1'b0, 8'h7E};
    vecs[4]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b0, 8'hA5, 1'b0, 17'h10000, 1'b0, 8'h00};
    vecs[5]  = '{1'b0, 32'h0003_0000, 8'h00, 1'b1, 8'h5A, 1'b0, 17'h10000, 1'b1, 8'h5A};
    vecs[6]  = '{1'b0, 32'h8000_0100, 8'h00, 1'b0, 8'h00, 1'b0, 17'h00100, 1'b0, 8'h41};
    vecs[7]  = '{1'b1, 32'h0003_0000, 8'h00, 1'b0, 8'h00, 1'b0, 17'h10000, 1'b0, 8'h41};
    vecs[8]  = '{1'b0, 32'h000F_0000, 8'h00, 1'b1, 8'h33, 1'b0, 17'h10000, 1'b1, 8'h33};
    vecs[9]  = '{1'b1, 32'h0002_0100, 8'h99, 1'b0, 8'h00, 1'b1, 17'h00100, 1'b0, 8'h33};
    vecs[10] = '{1'b0, 32'h0000_0100, 8'h00, 1'b0, 8'h00, 1'b0, 17'h00100, 1'b0, 8'h99};

    // Reset state
    do_reset();
    check("rst_mem_din", bus.mem_din, 8'h00);
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_io_full", bus.io_buffer_full, 1'b0);
    check("rst_finish", program_finish, 1'b0);
    check("rst_overflow", tx_overflow, 1'b0);
    check("rst_ram_we", ram_we, 1'b0);
    check("rst_rx_pop", rx_pop, 1'b0);

    // Single-cycle access table
    for (int i = 0; i < 11; i++) begin
      drive(1'b1, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      rx_valid = vecs[i].rxv;
      rx_data  = vecs[i].rxd;
      #1;
      check($sformatf("vec%0d_ram_we", i), ram_we, vecs[i].exp_we);
      check($sformatf("vec%0d_ram_addr", i), ram_addr, vecs[i].exp_addr);
      check($sformatf("vec%0d_rx_pop", i), rx_pop, vecs[i].exp_pop);
      step();
      check($sformatf("vec%0d_mem_din", i), bus.mem_din, vecs[i].exp_din);
      $display("vec %0d: wr=%0b a=0x%08h d=0x%02h -> din=0x%02h", i, vecs[i].wr, vecs[i].addr,
               vecs[i].wdata, bus.mem_din);
    end
    rx_valid = 1'b0;
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    step();
    check("zero_write_no_push", tx_valid, 1'b0);

    // Cycle counter: 20 ready cycles out of 25, then a coherent 4-byte load
    do_reset();
    for (int i = 0; i < 25; i++) begin
      drive((i % 5) != 2, 1'b0, 32'h0, 8'h00);
      step();
    end
    rd(32'h0003_0004, 8'd20, "clk_b0");
    rd(32'h0003_0005, 8'h00, "clk_b1");
    rd(32'h0003_0006, 8'h00, "clk_b2");
    rd(32'h0003_0007, 8'h00, "clk_b3");
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    step();
    check("clk_din_hold", bus.mem_din, 8'h00);
    rd(32'h0003_0004, 8'd24, "clk_resnap");
    for (int i = 0; i < 230; i++) begin
      drive(1'b1, 1'b0, 32'h0, 8'h00);
      step();
    end
    rd(32'h0003_0004, 8'hFF, "clk_roll_b0");
    rd(32'h0003_0005, 8'h00, "clk_roll_b1");

    // TX FIFO fill, near-full flag, overflow, in-order drain
    do_reset();
    for (int k = 1; k <= 16; k++) begin
      wr(32'h0003_0000, 8'h60 + 8'(k));
      check($sformatf("fill%0d_io_full", k), bus.io_buffer_full, k >= 14);
      check($sformatf("fill%0d_tx_valid", k), tx_valid, 1'b1);
    end
    check("fill_no_overflow", tx_overflow, 1'b0);
    wr(32'h0003_0000, 8'h71);
    check("overflow_set", tx_overflow, 1'b1);
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    tx_ready = 1'b1;
    for (int c = 0; c < 40 && tx_q.size() < 16; c++) step();
    check("drain_count", tx_q.size(), 16);
    for (int i = 0; i < 16 && i < tx_q.size(); i++) begin
      check($sformatf("drain_byte%0d", i), tx_q[i], 8'h61 + 8'(i));
      $display("tx byte %0d: 0x%02h", i, tx_q[i]);
    end
    step();
    check("drain_tx_valid", tx_valid, 1'b0);
    check("drain_io_full", bus.io_buffer_full, 1'b0);
    check("overflow_sticky", tx_overflow, 1'b1);

    // Asynchronous reset mid-operation discards queued bytes
    tx_ready = 1'b0;
    wr(32'h0003_0000, 8'h21);
    wr(32'h0003_0000, 8'h22);
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_tx_valid", tx_valid, 1'b0);
    check("async_rst_overflow", tx_overflow, 1'b0);
    do_reset();

    // Stop sequence with 3 bytes queued
    wr(32'h0003_0000, 8'h78);
    wr(32'h0003_0000, 8'h79);
    wr(32'h0003_0000, 8'h7A);
    tx_ready = 1'b1;
    wr(32'h0003_0004, 8'h55);
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    got     = 1'b0;
    prev_v  = tx_valid;
    prev2_v = 1'b0;
    pf_prev = program_finish;
    for (int c = 0; c < 40 && !got; c++) begin
      prev2_v = prev_v;
      prev_v  = tx_valid;
      pf_prev = program_finish;
      step();
      if (program_finish) begin
        got = 1'b1;
        check("finish_timing", {prev2_v, prev_v, pf_prev}, 3'b100);
      end
    end
    check("finish_reached", got, 1'b1);
    check("stop_tx_count", tx_q.size(), 4);
    if (tx_q.size() == 4) begin
      check("stop_b0", tx_q[0], 8'h78);
      check("stop_b1", tx_q[1], 8'h79);
      check("stop_b2", tx_q[2], 8'h7A);
      check("stop_b3", tx_q[3], 8'h00);
    end
    drive(1'b1, 1'b1, 32'h0003_0000, 8'h6B);
    #1;
    check("done_io_no_ram_we", ram_we, 1'b0);
    step();
    $display("write 0x30000 <- 0x6b (after stop)");
    check("done_io_ignored", tx_valid, 1'b0);
    drive(1'b1, 1'b1, 32'h0000_0200, 8'h66);
    #1;
    check("done_ram_we", ram_we, 1'b1);
    step();
    rd(32'h0000_0200, 8'h66, "done_ram_read");
    check("done_finish_held", program_finish, 1'b1);
    check("done_no_overflow", tx_overflow, 1'b0);

    // Stop request while the FIFO is full waits for a free slot
    do_reset();
    for (int k = 0; k < 16; k++) wr(32'h0003_0000, 8'h41 + 8'(k));
    wr(32'h0003_0004, 8'h01);
    drive(1'b0, 1'b0, 32'h0, 8'h00);
    step();
    step();
    check("stopwait_not_finished", program_finish, 1'b0);
    tx_ready = 1'b1;
    got = 1'b0;
    for (int c = 0; c < 60 && !got; c++) begin
      step();
      got = program_finish;
    end
    check("stopwait_finish", got, 1'b1);
    check("stopwait_count", tx_q.size(), 17);
    if (tx_q.size() == 17) begin
      check("stopwait_first", tx_q[0], 8'h41);
      check("stopwait_last", tx_q[16], 8'h00);
    end
    check("stopwait_no_overflow", tx_overflow, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
